top_level: RTL and testbench
============================

# top_level

Peripheral top for the serial-clock domain. It bundles three blocks on one clock:
- a 1:2 serial-to-parallel deserializer;
- an interval timer with a 16-bit CSR slave;
- an 8N1 UART with a 16-bit CSR slave.

Both slaves use the Avalon-style active-low strobes of the bus fabric. Each peripheral raises a level interrupt to the system interrupt controller.

## Interface
Clock: one clock; reset is synchronous and active-high (`serial_clk`, `reset`).

Parameters:
- `TIMER_PERIOD`, default 100: reset value of the 32-bit timer period, in cycles.
- `UART_DIV`, default 8: clocks per UART bit; fixed, not writable.

Ports:
- `serial_clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `serial_data` in 1: serial bit stream.
- `parallel_data` out 2: deserialized pair.
- `timer_csr_address` in 3; `timer_csr_writedata` in 16; `timer_csr_readdata` out 16.
- `timer_csr_chipselect` in 1; `timer_csr_write_n` in 1.
- `timer_irq_irq` out 1.
- `uart_rxd` in 1; `uart_txd` out 1.
- `uart_csr_address` in 3; `uart_csr_begintransfer` in 1; `uart_csr_chipselect` in 1.
- `uart_csr_read_n` in 1; `uart_csr_write_n` in 1.
- `uart_csr_writedata` in 16; `uart_csr_readdata` out 16.
- `uart_irq_irq` out 1.

## Operation
Deserializer
- Shifts in `serial_data` every cycle using a 1-bit phase counter.
- On phase 1: `parallel_data <= {previous bit, current bit}` (first-received bit is the MSB).

Timer registers (write when `chipselect & ~write_n`):
- Addr 0, status: bit0 TO, bit1 RUN (RO). Any write clears TO.
- Addr 1, control: bit0 ITO, bit1 CONT, bit2 START (write-only pulse), bit3 STOP (write-only pulse).
  - A write with START=1 or CONT=1 sets RUN and reloads the counter.
  - STOP=1 clears RUN; STOP wins over START.
- Addr 2, period[15:0]; addr 3, period[31:16]. A write stops the timer and reloads the counter.
- Other addresses read 0.

Timer counting:
- While RUN, the counter decrements each cycle.
- At 0 it sets TO and reloads period. If CONT=0 it also clears RUN.
- `timer_irq_irq = TO & ITO`.
- When clearing TO and a timeout happen in the same cycle, the timeout wins.

UART registers
- Side effects (writes, read-clears) occur only when `chipselect & begintransfer`.
- Addr 0, rxdata[7:0]: a read clears RRDY.
- Addr 1, txdata[7:0]: a write while TRDY=1 loads the holding register. A write while TRDY=0 sets TOE and drops the data.
- Addr 2, status:
  - bits: 1 FE, 3 ROE, 4 TOE, 5 TMT, 6 TRDY, 7 RRDY.
  - Any write clears FE, ROE and TOE.
- Addr 3, control: bits 3 IROE, 5 ITMT, 6 ITRDY, 7 IRRDY.
- Addr 4, divisor: reads `UART_DIV`.

UART datapath:
- TX frame: start 0, 8 data bits LSB first, stop 1; `uart_txd` idles high.
- TRDY = holding register empty.
- TMT = holding register empty and shifter idle.
- RX:
  - Start detected on a falling edge of `uart_rxd`, after a 2-flop synchronizer.
  - Data bits sampled at mid-bit.
  - A stop bit of 0 sets FE.
  - On stop, the byte goes to rxdata and sets RRDY. If RRDY was already 1, ROE is set and rxdata is overwritten.
- `uart_irq_irq = (RRDY&IRRDY)|(TRDY&ITRDY)|(TMT&ITMT)|((ROE|TOE)&IROE)`.

## Timing
- Reset values:
  - `parallel_data` = 0.
  - Both readdata buses = 0.
  - Both irqs = 0.
  - `uart_txd` = 1.
  - Timer: TO=0, RUN=0, control=0, period=`TIMER_PERIOD`.
  - UART: status TRDY=1, TMT=1, others 0; control=0.
- Readdata on both slaves is registered, with a 1-cycle latency after `chipselect` (UART also qualifies with `~read_n`). It holds its value until the next read.
- Register writes take effect on the edge where the strobe is sampled. Status bits reflect the write one cycle later.
- The holding register moves to the shifter within 1 cycle of the shifter going idle. TRDY returns to 1 on that transfer.
- RRDY asserts in the cycle after the stop-bit sample.
- The first timeout occurs `period+1` cycles after the starting write.
- Period 0 means a timeout every cycle.

## Structure
- Shared package `top_level_pkg`:
  - timer and UART address constants;
  - status/control bit indices;
  - `typedef enum {IDLE, START, DATA, STOP}` for the TX and RX FSMs.
- Sub-modules: `interval_timer`, `uart_8n1`, `deser_1to2`, instantiated by `top_level`. No deeper hierarchy.

## Test plan
- Reset, then read timer addr 0/1 and UART addr 2 → 0x0000, 0x0000, 0x0060; `uart_txd`=1.
- Write timer ctrl=0x0003 (ITO|CONT) → `timer_irq_irq` rises 101 cycles later and status reads 0b11. Write status 0 → irq drops next cycle and recurs every 101 cycles.
- Write timer ctrl=0x0005 (ITO|START) → one timeout, then RUN=0 and status reads 0b01.
- Loop `uart_txd`→`uart_rxd`, write ctrl=0x0080 and txdata=0xA5 → status drops TRDY, then TMT. After ~10×8 cycles `uart_irq_irq`=1, RRDY=1, rxdata=0xA5. The rxdata read clears RRDY and the irq.
- Two bytes received without reading → ROE=1. Writing status → ROE=0.
- Drive `serial_data` 1,0,1,1 → `parallel_data` 2'b10 then 2'b11.

Source files
------------

// File: rtl/top_level_pkg.sv
// Shared constants and types for the serial-clock peripheral slice.
// Register maps, bit positions and the serial FSM state encoding.
package top_level_pkg;

    localparam logic [2:0] T_STATUS  = 3'd0;
    localparam logic [2:0] T_CONTROL = 3'd1;
    localparam logic [2:0] T_PERIODL = 3'd2;
    localparam logic [2:0] T_PERIODH = 3'd3;

    localparam logic [2:0] U_RXDATA  = 3'd0;
    localparam logic [2:0] U_TXDATA  = 3'd1;
    localparam logic [2:0] U_STATUS  = 3'd2;
    localparam logic [2:0] U_CONTROL = 3'd3;
    localparam logic [2:0] U_DIVISOR = 3'd4;

    localparam int T_ITO   = 0;
    localparam int T_CONT  = 1;
    localparam int T_START = 2;
    localparam int T_STOP  = 3;

    localparam int U_FE    = 1;
    localparam int U_ROE   = 3;
    localparam int U_TOE   = 4;
    localparam int U_TMT   = 5;
    localparam int U_TRDY  = 6;
    localparam int U_RRDY  = 7;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

endpackage

// File: rtl/deser_1to2.sv
// 1:2 serial-to-parallel deserializer.
// The first bit of each pair lands in the MSB.
module deser_1to2
    import top_level_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data,
    output logic [1:0] o_data
);

    logic       r_phase;
    logic       r_prev;
    logic [1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= 1'b0;
            r_prev  <= 1'b0;
            r_data  <= 2'b00;
        end else begin
            r_phase <= ~r_phase;
            r_prev  <= i_data;
            if (r_phase)
                r_data <= {r_prev, i_data};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/interval_timer.sv
// 32-bit interval timer with a 16-bit CSR slave.
// Timeout fires period+1 cycles after a (re)load.
module interval_timer
    import top_level_pkg::*;
#(
    parameter int unsigned TIMER_PERIOD = 100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_addr,
    input  logic [15:0] i_wdata,
    input  logic        i_cs,
    input  logic        i_write_n,
    output logic [15:0] o_rdata,
    output logic        o_irq
);

    logic        r_to;
    logic        r_run;
    logic        r_ito;
    logic        r_cont;
    logic [31:0] r_period;
    logic [31:0] r_count;
    logic [15:0] r_rdata;

    logic        w_wr;
    logic        w_tmo;
    logic [15:0] w_rmux;

    assign w_wr  = i_cs & ~i_write_n;
    assign w_tmo = r_run & (r_count == 32'd0);

    always_comb begin
        w_rmux = 16'h0000;
        case (i_addr)
            T_STATUS:  w_rmux = {14'd0, r_run, r_to};
            T_CONTROL: w_rmux = {14'd0, r_cont, r_ito};
            T_PERIODL: w_rmux = r_period[15:0];
            T_PERIODH: w_rmux = r_period[31:16];
            default:   w_rmux = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to     <= 1'b0;
            r_run    <= 1'b0;
            r_ito    <= 1'b0;
            r_cont   <= 1'b0;
            r_period <= 32'(TIMER_PERIOD);
            r_count  <= 32'(TIMER_PERIOD);
            r_rdata  <= 16'h0000;
        end else begin
            if (i_cs)
                r_rdata <= w_rmux;
            if (r_run) begin
                if (w_tmo) begin
                    r_count <= r_period;
                    r_run   <= r_cont;
                end else begin
                    r_count <= r_count - 32'd1;
                end
            end
            // A timeout beats a simultaneous status-write clear
            if (w_tmo)
                r_to <= 1'b1;
            else if (w_wr && i_addr == T_STATUS)
                r_to <= 1'b0;
            if (w_wr) begin
                case (i_addr)
                    T_CONTROL: begin
                        r_ito  <= i_wdata[T_ITO];
                        r_cont <= i_wdata[T_CONT];
                        if (i_wdata[T_STOP]) begin
                            r_run <= 1'b0;
                        end else if (i_wdata[T_START] | i_wdata[T_CONT]) begin
                            r_run   <= 1'b1;
                            r_count <= r_period;
                        end
                    end
                    T_PERIODL: begin
                        r_period[15:0] <= i_wdata;
                        r_run          <= 1'b0;
                        r_count        <= {r_period[31:16], i_wdata};
                    end
                    T_PERIODH: begin
                        r_period[31:16] <= i_wdata;
                        r_run           <= 1'b0;
                        r_count         <= {i_wdata, r_period[15:0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_irq   = r_to & r_ito;

endmodule

// File: rtl/uart_8n1.sv
// 8N1 UART with a fixed bit divisor and a 16-bit CSR slave.
// Single-byte holding register in front of the TX shifter.
module uart_8n1
    import top_level_pkg::*;
#(
    parameter int unsigned UART_DIV = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rxd,
    output logic        o_txd,
    input  logic [2:0]  i_addr,
    input  logic        i_begin,
    input  logic        i_cs,
    input  logic        i_read_n,
    input  logic        i_write_n,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_irq
);

    localparam logic [15:0] DIV_M1  = 16'(UART_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(UART_DIV / 2 - 1);

    logic        r_fe, r_roe, r_toe, r_rrdy;
    logic        r_iroe, r_itmt, r_itrdy, r_irrdy;
    logic [15:0] r_rdata;

    ser_state_t  r_tx_st;
    logic [7:0]  r_thr;
    logic        r_thr_full;
    logic [7:0]  r_tx_sh;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic        r_txd;

    ser_state_t  r_rx_st;
    logic        r_rx_s1, r_rx_s2, r_rx_d;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;
    logic [7:0]  r_rx_data;

    logic        w_wr, w_rd, w_trdy, w_tmt, w_rx_fall;
    logic [15:0] w_rmux;

    assign w_wr      = i_cs & i_begin & ~i_write_n;
    assign w_rd      = i_cs & i_begin & ~i_read_n;
    assign w_trdy    = ~r_thr_full;
    assign w_tmt     = ~r_thr_full & (r_tx_st == IDLE);
    assign w_rx_fall = r_rx_d & ~r_rx_s2;

    always_comb begin
        w_rmux = 16'h0000;
        case (i_addr)
            U_RXDATA:  w_rmux = {8'd0, r_rx_data};
            U_STATUS:  w_rmux = {8'd0, r_rrdy, w_trdy, w_tmt, r_toe,
                                 r_roe, 1'b0, r_fe, 1'b0};
            U_CONTROL: w_rmux = {8'd0, r_irrdy, r_itrdy, r_itmt, 1'b0,
                                 r_iroe, 3'd0};
            U_DIVISOR: w_rmux = 16'(UART_DIV);
            default:   w_rmux = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iroe  <= 1'b0;
            r_itmt  <= 1'b0;
            r_itrdy <= 1'b0;
            r_irrdy <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            if (w_wr && i_addr == U_CONTROL) begin
                r_iroe  <= i_wdata[3];
                r_itmt  <= i_wdata[5];
                r_itrdy <= i_wdata[6];
                r_irrdy <= i_wdata[7];
            end
            if (i_cs & ~i_read_n)
                r_rdata <= w_rmux;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_st    <= IDLE;
            r_thr      <= 8'd0;
            r_thr_full <= 1'b0;
            r_tx_sh    <= 8'd0;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_txd      <= 1'b1;
            r_toe      <= 1'b0;
        end else begin
            if (w_wr && i_addr == U_STATUS)
                r_toe <= 1'b0;
            if (w_wr && i_addr == U_TXDATA) begin
                if (r_thr_full) begin
                    r_toe <= 1'b1;
                end else begin
                    r_thr      <= i_wdata[7:0];
                    r_thr_full <= 1'b1;
                end
            end
            unique case (r_tx_st)
                IDLE: if (r_thr_full) begin
                    r_tx_sh    <= r_thr;
                    r_thr_full <= 1'b0;
                    r_txd      <= 1'b0;
                    r_tx_cnt   <= DIV_M1;
                    r_tx_st    <= START;
                end
                START: if (r_tx_cnt != 16'd0) begin
                    r_tx_cnt <= r_tx_cnt - 16'd1;
                end else begin
                    r_txd    <= r_tx_sh[0];
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= 3'd0;
                    r_tx_cnt <= DIV_M1;
                    r_tx_st  <= DATA;
                end
                DATA: if (r_tx_cnt != 16'd0) begin
                    r_tx_cnt <= r_tx_cnt - 16'd1;
                end else begin
                    r_tx_cnt <= DIV_M1;
                    if (r_tx_bit == 3'd7) begin
                        r_txd   <= 1'b1;
                        r_tx_st <= STOP;
                    end else begin
                        r_txd    <= r_tx_sh[0];
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                end
                STOP: if (r_tx_cnt != 16'd0)
                    r_tx_cnt <= r_tx_cnt - 16'd1;
                else
                    r_tx_st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_d    <= 1'b1;
            r_rx_st   <= IDLE;
            r_rx_cnt  <= 16'd0;
            r_rx_bit  <= 3'd0;
            r_rx_sh   <= 8'd0;
            r_rx_data <= 8'd0;
            r_rrdy    <= 1'b0;
            r_roe     <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_rx_s1 <= i_rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            if (w_rd && i_addr == U_RXDATA)
                r_rrdy <= 1'b0;
            if (w_wr && i_addr == U_STATUS) begin
                r_fe  <= 1'b0;
                r_roe <= 1'b0;
            end
            unique case (r_rx_st)
                IDLE: if (w_rx_fall) begin
                    r_rx_cnt <= HALF_M1;
                    r_rx_st  <= START;
                end
                // Mid start bit: a high line here was a glitch
                START: if (r_rx_cnt != 16'd0) begin
                    r_rx_cnt <= r_rx_cnt - 16'd1;
                end else if (r_rx_s2) begin
                    r_rx_st <= IDLE;
                end else begin
                    r_rx_cnt <= DIV_M1;
                    r_rx_bit <= 3'd0;
                    r_rx_st  <= DATA;
                end
                DATA: if (r_rx_cnt != 16'd0) begin
                    r_rx_cnt <= r_rx_cnt - 16'd1;
                end else begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_cnt <= DIV_M1;
                    r_rx_bit <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7)
                        r_rx_st <= STOP;
                end
                STOP: if (r_rx_cnt != 16'd0) begin
                    r_rx_cnt <= r_rx_cnt - 16'd1;
                end else begin
                    r_rx_data <= r_rx_sh;
                    r_rrdy    <= 1'b1;
                    if (r_rrdy)
                        r_roe <= 1'b1;
                    if (!r_rx_s2)
                        r_fe <= 1'b1;
                    r_rx_st <= IDLE;
                end
            endcase
        end
    end

    assign o_txd   = r_txd;
    assign o_rdata = r_rdata;
    assign o_irq   = (r_rrdy & r_irrdy) | (w_trdy & r_itrdy)
                   | (w_tmt & r_itmt) | ((r_roe | r_toe) & r_iroe);

endmodule

// File: rtl/top_level.sv
// Serial-clock peripheral top: deserializer, interval timer, UART.
// All three blocks share one clock and a synchronous reset.
module top_level
    import top_level_pkg::*;
#(
    parameter int unsigned TIMER_PERIOD = 100,
    parameter int unsigned UART_DIV     = 8
) (
    input  logic        serial_clk,
    input  logic        reset,
    input  logic        serial_data,
    output logic [1:0]  parallel_data,
    input  logic [2:0]  timer_csr_address,
    input  logic [15:0] timer_csr_writedata,
    output logic [15:0] timer_csr_readdata,
    input  logic        timer_csr_chipselect,
    input  logic        timer_csr_write_n,
    output logic        timer_irq_irq,
    input  logic        uart_rxd,
    output logic        uart_txd,
    input  logic [2:0]  uart_csr_address,
    input  logic        uart_csr_begintransfer,
    input  logic        uart_csr_chipselect,
    input  logic        uart_csr_read_n,
    input  logic        uart_csr_write_n,
    input  logic [15:0] uart_csr_writedata,
    output logic [15:0] uart_csr_readdata,
    output logic        uart_irq_irq
);

    deser_1to2 u_deser (
        .i_clk  (serial_clk),
        .i_rst  (reset),
        .i_data (serial_data),
        .o_data (parallel_data)
    );

    interval_timer #(
        .TIMER_PERIOD (TIMER_PERIOD)
    ) u_timer (
        .i_clk     (serial_clk),
        .i_rst     (reset),
        .i_addr    (timer_csr_address),
        .i_wdata   (timer_csr_writedata),
        .i_cs      (timer_csr_chipselect),
        .i_write_n (timer_csr_write_n),
        .o_rdata   (timer_csr_readdata),
        .o_irq     (timer_irq_irq)
    );

    uart_8n1 #(
        .UART_DIV (UART_DIV)
    ) u_uart (
        .i_clk     (serial_clk),
        .i_rst     (reset),
        .i_rxd     (uart_rxd),
        .o_txd     (uart_txd),
        .i_addr    (uart_csr_address),
        .i_begin   (uart_csr_begintransfer),
        .i_cs      (uart_csr_chipselect),
        .i_read_n  (uart_csr_read_n),
        .i_write_n (uart_csr_write_n),
        .i_wdata   (uart_csr_writedata),
        .o_rdata   (uart_csr_readdata),
        .o_irq     (uart_irq_irq)
    );

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: deserializer, timer, UART loopback.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_top_level;

    logic        serial_clk = 1'b0;
    logic        reset;
    logic        serial_data;
    logic [1:0]  parallel_data;
    logic [2:0]  timer_csr_address;
    logic [15:0] timer_csr_writedata;
    logic [15:0] timer_csr_readdata;
    logic        timer_csr_chipselect;
    logic        timer_csr_write_n;
    logic        timer_irq_irq;
    logic        uart_rxd;
    logic        uart_txd;
    logic [2:0]  uart_csr_address;
    logic        uart_csr_begintransfer;
    logic        uart_csr_chipselect;
    logic        uart_csr_read_n;
    logic        uart_csr_write_n;
    logic [15:0] uart_csr_writedata;
    logic [15:0] uart_csr_readdata;
    logic        uart_irq_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 serial_clk = ~serial_clk;

    assign uart_rxd = uart_txd;

    top_level dut (
        .serial_clk             (serial_clk),
        .reset                  (reset),
        .serial_data            (serial_data),
        .parallel_data          (parallel_data),
        .timer_csr_address      (timer_csr_address),
        .timer_csr_writedata    (timer_csr_writedata),
        .timer_csr_readdata     (timer_csr_readdata),
        .timer_csr_chipselect   (timer_csr_chipselect),
        .timer_csr_write_n      (timer_csr_write_n),
        .timer_irq_irq          (timer_irq_irq),
        .uart_rxd               (uart_rxd),
        .uart_txd               (uart_txd),
        .uart_csr_address       (uart_csr_address),
        .uart_csr_begintransfer (uart_csr_begintransfer),
        .uart_csr_chipselect    (uart_csr_chipselect),
        .uart_csr_read_n        (uart_csr_read_n),
        .uart_csr_write_n       (uart_csr_write_n),
        .uart_csr_writedata     (uart_csr_writedata),
        .uart_csr_readdata      (uart_csr_readdata),
        .uart_irq_irq           (uart_irq_irq)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic t_wr(input logic [2:0] a, input logic [15:0] d);
        timer_csr_address    = a;
        timer_csr_writedata  = d;
        timer_csr_chipselect = 1'b1;
        timer_csr_write_n    = 1'b0;
        @(posedge serial_clk);
        @(negedge serial_clk);
        timer_csr_chipselect = 1'b0;
        timer_csr_write_n    = 1'b1;
    endtask

    task automatic t_rd(input logic [2:0] a, output logic [15:0] d);
        timer_csr_address    = a;
        timer_csr_chipselect = 1'b1;
        @(posedge serial_clk);
        @(negedge serial_clk);
        timer_csr_chipselect = 1'b0;
        d = timer_csr_readdata;
    endtask

    task automatic u_wr(input logic [2:0] a, input logic [15:0] d);
        uart_csr_address       = a;
        uart_csr_writedata     = d;
        uart_csr_chipselect    = 1'b1;
        uart_csr_begintransfer = 1'b1;
        uart_csr_write_n       = 1'b0;
        @(posedge serial_clk);
        @(negedge serial_clk);
        uart_csr_chipselect    = 1'b0;
        uart_csr_begintransfer = 1'b0;
        uart_csr_write_n       = 1'b1;
    endtask

    task automatic u_rd(input logic [2:0] a, output logic [15:0] d);
        uart_csr_address       = a;
        uart_csr_chipselect    = 1'b1;
        uart_csr_begintransfer = 1'b1;
        uart_csr_read_n        = 1'b0;
        @(posedge serial_clk);
        @(negedge serial_clk);
        uart_csr_chipselect    = 1'b0;
        uart_csr_begintransfer = 1'b0;
        uart_csr_read_n        = 1'b1;
        d = uart_csr_readdata;
    endtask

    task automatic wait_uirq(input string tag);
        int n = 0;
        while (!uart_irq_irq && n < 400) begin
            @(negedge serial_clk);
            n++;
        end
        chk(tag, 16'(uart_irq_irq), 16'h0001);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        reset                  = 1'b1;
        serial_data            = 1'b1;
        timer_csr_address      = 3'd0;
        timer_csr_writedata    = 16'h0000;
        timer_csr_chipselect   = 1'b0;
        timer_csr_write_n      = 1'b1;
        uart_csr_address       = 3'd0;
        uart_csr_writedata     = 16'h0000;
        uart_csr_chipselect    = 1'b0;
        uart_csr_begintransfer = 1'b0;
        uart_csr_read_n        = 1'b1;
        uart_csr_write_n       = 1'b1;
        repeat (3) @(posedge serial_clk);
        @(negedge serial_clk);

        chk("rst_pdata", 16'(parallel_data), 16'h0000);
        chk("rst_tirq", 16'(timer_irq_irq), 16'h0000);
        chk("rst_uirq", 16'(uart_irq_irq), 16'h0000);
        chk("rst_txd", 16'(uart_txd), 16'h0001);
        chk("rst_trd", timer_csr_readdata, 16'h0000);
        chk("rst_urd", uart_csr_readdata, 16'h0000);

        // Deserializer: bits 1,0 then 1,1
        reset = 1'b0;
        @(negedge serial_clk);
        serial_data = 1'b0;
        @(negedge serial_clk);
        chk("deser_10", 16'(parallel_data), 16'h0002);
        serial_data = 1'b1;
        @(negedge serial_clk);
        chk("deser_hold", 16'(parallel_data), 16'h0002);
        @(negedge serial_clk);
        chk("deser_11", 16'(parallel_data), 16'h0003);

        t_rd(3'd0, rd); chk("t_rst_status", rd, 16'h0000);
        t_rd(3'd1, rd); chk("t_rst_ctrl", rd, 16'h0000);
        t_rd(3'd2, rd); chk("t_rst_perl", rd, 16'h0064);
        u_rd(3'd2, rd); chk("u_rst_status", rd, 16'h0060);
        u_rd(3'd4, rd); chk("u_divisor", rd, 16'h0008);

        // Continuous timer with interrupt
        t_wr(3'd1, 16'h0003);
        repeat (100) @(negedge serial_clk);
        chk("t_irq_pre", 16'(timer_irq_irq), 16'h0000);
        @(negedge serial_clk);
        chk("t_irq_101", 16'(timer_irq_irq), 16'h0001);
        t_rd(3'd0, rd); chk("t_status_11", rd, 16'h0003);
        t_wr(3'd0, 16'h0000);
        chk("t_irq_clr", 16'(timer_irq_irq), 16'h0000);
        repeat (98) @(negedge serial_clk);
        chk("t_irq_pre2", 16'(timer_irq_irq), 16'h0000);
        @(negedge serial_clk);
        chk("t_irq_again", 16'(timer_irq_irq), 16'h0001);

        // One-shot
        t_wr(3'd1, 16'h0005);
        t_wr(3'd0, 16'h0000);
        chk("t_os_clr", 16'(timer_irq_irq), 16'h0000);
        repeat (99) @(negedge serial_clk);
        chk("t_os_pre", 16'(timer_irq_irq), 16'h0000);
        @(negedge serial_clk);
        chk("t_os_irq", 16'(timer_irq_irq), 16'h0001);
        t_rd(3'd0, rd); chk("t_os_status", rd, 16'h0001);
        repeat (150) @(negedge serial_clk);
        t_rd(3'd0, rd); chk("t_os_stays", rd, 16'h0001);

        // Period 0: timeout every cycle, beats a status clear
        t_wr(3'd0, 16'h0000);
        t_wr(3'd2, 16'h0000);
        t_wr(3'd1, 16'h0007);
        t_wr(3'd0, 16'h0000);
        chk("t_p0_tmo_wins", 16'(timer_irq_irq), 16'h0001);
        t_rd(3'd0, rd); chk("t_p0_status", rd, 16'h0003);
        t_wr(3'd1, 16'h0009);
        t_wr(3'd0, 16'h0000);
        t_rd(3'd0, rd); chk("t_stop", rd, 16'h0000);
        t_wr(3'd1, 16'h000C);
        t_rd(3'd0, rd); chk("t_stop_wins", rd, 16'h0000);
        t_rd(3'd2, rd); chk("t_perl_0", rd, 16'h0000);
        t_rd(3'd5, rd); chk("t_unmapped", rd, 16'h0000);

        // UART loopback of one byte
        u_wr(3'd3, 16'h0080);
        u_wr(3'd1, 16'h00A5);
        u_rd(3'd2, rd); chk("u_trdy_drop", rd, 16'h0000);
        u_rd(3'd2, rd); chk("u_tmt_drop", rd, 16'h0040);
        chk("u_irq_idle", 16'(uart_irq_irq), 16'h0000);
        wait_uirq("u_irq_rx");
        repeat (20) @(negedge serial_clk);
        u_rd(3'd2, rd); chk("u_rrdy", rd, 16'h00E0);
        u_rd(3'd0, rd); chk("u_rxdata_a5", rd, 16'h00A5);
        chk("u_irq_clr", 16'(uart_irq_irq), 16'h0000);
        u_rd(3'd2, rd); chk("u_rrdy_clr", rd, 16'h0060);

        // Overrun: two bytes without reading
        u_wr(3'd1, 16'h003C);
        @(negedge serial_clk);
        u_wr(3'd1, 16'h005A);
        repeat (250) @(negedge serial_clk);
        u_rd(3'd2, rd); chk("u_roe_set", rd, 16'h00E8);
        u_wr(3'd2, 16'h0000);
        u_rd(3'd2, rd); chk("u_roe_clr", rd, 16'h00E0);
        u_rd(3'd0, rd); chk("u_rxdata_5a", rd, 16'h005A);
        u_rd(3'd2, rd); chk("u_idle2", rd, 16'h0060);

        // TX overrun: second write while holding register full
        u_wr(3'd3, 16'h0088);
        u_wr(3'd1, 16'h0011);
        u_wr(3'd1, 16'h0022);
        chk("u_toe_irq", 16'(uart_irq_irq), 16'h0001);
        u_rd(3'd2, rd); chk("u_toe_status", rd, 16'h0050);
        u_rd(3'd3, rd); chk("u_ctrl", rd, 16'h0088);
        u_wr(3'd2, 16'h0000);
        chk("u_toe_irq_clr", 16'(uart_irq_irq), 16'h0000);
        wait_uirq("u_irq_rx2");
        u_rd(3'd0, rd); chk("u_rxdata_11", rd, 16'h0011);
        repeat (20) @(negedge serial_clk);
        u_rd(3'd2, rd); chk("u_final", rd, 16'h0060);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
